// File: rtl/sync_fifo_pkg.sv
// Shared FIFO definitions: default sizing constants and the clog2 helper,
// kept separate so future async/multi-channel FIFO variants can reuse them.
package sync_fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AEMPTY_TH = 2;

  // Ceiling log2, usable in constant expressions for address widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write port and a registered
// read port whose output register resets to zero (the array itself does not).
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A same-cycle write to rd_addr (full FIFO, read+write) returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO: pointers, occupancy count, flag decode and
// overflow/underflow pulses around a registered-read storage array.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // No bypass: an empty FIFO never serves a read, even with a concurrent write.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AFULL_TH));
  assign almost_empty = (count <= CNT_W'(AEMPTY_TH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      rd_valid  <= rd_ok;
      overflow  <= wr_en && full && !rd_ok;
      underflow <= rd_en && empty;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=16, DATA_W=8) with a queue reference
// model checked every cycle plus hand-computed expectations per scenario.
module tb_sync_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int         vectors;
  int         miscompares;
  logic [7:0] model_q[$];
  logic [7:0] exp_rd_data;

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors = vectors + 1;
    if (observed !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock of stimulus; the queue model predicts every output for the next cycle.
  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic rd);
    int   sz;
    logic m_rd_ok;
    logic m_wr_ok;
    logic exp_ovf;
    logic exp_udf;
    sz      = model_q.size();
    m_rd_ok = rd && (sz > 0);
    m_wr_ok = wr && ((sz < DEPTH) || m_rd_ok);
    exp_ovf = wr && (sz == DEPTH) && !m_rd_ok;
    exp_udf = rd && (sz == 0);
    if (m_rd_ok) exp_rd_data = model_q.pop_front();
    if (m_wr_ok) model_q.push_back(data);
    wr_en   = wr;
    wr_data = data;
    rd_en   = rd;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    sz = model_q.size();
    checkOutput("rd_valid", rd_valid, m_rd_ok);
    checkOutput("rd_data", rd_data, exp_rd_data);
    checkOutput("count", count, sz);
    checkOutput("full", full, sz == DEPTH);
    checkOutput("empty", empty, sz == 0);
    checkOutput("almost_full", almost_full, sz >= DEPTH - 2);
    checkOutput("almost_empty", almost_empty, sz <= 2);
    checkOutput("overflow", overflow, exp_ovf);
    checkOutput("underflow", underflow, exp_udf);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"}, count, 0);
    checkOutput({tag, "_empty"}, empty, 1);
    checkOutput({tag, "_full"}, full, 0);
    checkOutput({tag, "_aempty"}, almost_empty, 1);
    checkOutput({tag, "_afull"}, almost_full, 0);
    checkOutput({tag, "_rd_valid"}, rd_valid, 0);
    checkOutput({tag, "_rd_data"}, rd_data, 0);
    checkOutput({tag, "_ovf"}, overflow, 0);
    checkOutput({tag, "_udf"}, underflow, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_rd_data = 8'h00;
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    rd_en       = 1'b0;
    #1;
    checkResetState("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-stream after five writes, asserted between clock edges.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
    checkOutput("pre_rst_count", count, 5);
    #2;
    rst = 1'b1;
    #1;
    checkResetState("mid_rst");
    model_q.delete();
    exp_rd_data = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_rst_udf", underflow, 1);

    // Fill and drain with 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      if (i == 12) checkOutput("afull_at13", almost_full, 0);
      if (i == 13) checkOutput("afull_at14", almost_full, 1);
    end
    checkOutput("fill_full", full, 1);
    checkOutput("fill_count", count, 16);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drain_data", rd_data, i);
      checkOutput("drain_valid", rd_valid, 1);
    end
    checkOutput("drain_empty", empty, 1);

    // Overflow on a full FIFO; 0xAA must never come back.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("ovf_pulse", overflow, 1);
    checkOutput("ovf_count", count, 16);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf_single", overflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("ovf_drain", rd_data, 8'h10 + 8'(i));
    end

    // Underflow with a simultaneous write: no bypass.
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("udf_pulse", underflow, 1);
    checkOutput("udf_valid", rd_valid, 0);
    checkOutput("udf_count", count, 1);
    checkOutput("udf_hold", rd_data, 8'h1F);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("udf_next", rd_data, 8'h55);

    // Simultaneous read and write on a full FIFO.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("rw_full_ovf", overflow, 0);
    checkOutput("rw_full_count", count, 16);
    checkOutput("rw_full_data", rd_data, 8'h20);
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("rw_full_drain", rd_data, 8'h20 + 8'(i));
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rw_full_last", rd_data, 8'h77);
    checkOutput("rw_full_empty", empty, 1);

    // Random traffic across pointer wrap, checked against the queue model.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
